muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit, parametrised in operand width. Sits beside the single-cycle ALU in the EX stage. The pipeline stalls on busy and captures result on done. Covers all eight M-extension funct3 ops: shift-add multiply and restoring divide, one bit per cycle, with sign fix-up and RISC-V special-case results.

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execute unit, one bit per cycle.
// Optional last-divide result cache enabled by defining MULDIV_DIV_CACHE_EN.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_next;
    logic [2:0]         op;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [CNT_W-1:0]   cnt;
    logic               neg_res, neg_rem;

    logic               is_div, sign_a, sign_b, div_zero, div_ovf, special, hit, accept;
    logic [WIDTH-1:0]   abs_a, abs_b, special_res, hit_res, fix_res, quo, rem;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // Operand decode and special-case detection for the op presented on the inputs
    always_comb begin
        is_div   = funct3[2];
        sign_a   = rs1_data[WIDTH-1] &&
                   (funct3 == 3'b001 || funct3 == 3'b010 || (is_div && !funct3[0]));
        sign_b   = rs2_data[WIDTH-1] && (funct3 == 3'b001 || (is_div && !funct3[0]));
        abs_a    = sign_a ? -rs1_data : rs1_data;
        abs_b    = sign_b ? -rs2_data : rs2_data;
        div_zero = is_div && (rs2_data == '0);
        div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_NEG) && (rs2_data == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_res = funct3[1] ? rs1_data : '1;
        else
            special_res = funct3[1] ? '0 : rs1_data;
        accept   = (state == IDLE || state == DONE) && start && !flush;
    end

`ifdef MULDIV_DIV_CACHE_EN
    logic             cache_valid, cache_s;
    logic [WIDTH-1:0] tag_a, tag_b, cache_a, cache_b, cache_q, cache_r;

    assign hit     = is_div && cache_valid && (rs1_data == cache_a) &&
                     (rs2_data == cache_b) && (cache_s == !funct3[0]);
    assign hit_res = funct3[1] ? cache_r : cache_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_s     <= 1'b0;
            tag_a       <= '0;
            tag_b       <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_q     <= '0;
            cache_r     <= '0;
        end else begin
            if (accept) begin
                tag_a <= rs1_data;
                tag_b <= rs2_data;
            end
            if (flush) begin
                cache_valid <= 1'b0;
            end else if (state == FIX && op[2]) begin
                cache_valid <= 1'b1;
                cache_a     <= tag_a;
                cache_b     <= tag_b;
                cache_s     <= !op[0];
                cache_q     <= quo;
                cache_r     <= rem;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // One iteration: shift-add for multiply, shift-subtract-restore for divide
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opb};
        if (!op[2])
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = (special || hit) ? DONE : CALC;
                else
                    state_next = IDLE;
            end
            CALC: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))
                    state_next = FIX;
            end
            FIX:     state_next = flush ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op      <= funct3;
                        opa     <= abs_a;
                        opb     <= abs_b;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                        if (special)
                            result <= special_res;
                        else if (hit)
                            result <= hit_res;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (!flush)
                        result <= fix_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam int FULL_LAT = W + 2;
`ifdef MULDIV_DIV_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = FULL_LAT;
`endif

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   funct3;
    logic [W-1:0] rs1_data, rs2_data;
    logic         busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Issues one op and waits (bounded) for done; lat=1 means done in the cycle after start.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cyc, output logic [W-1:0] res);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result} !== {2'b00, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        int lat, bc;
        logic [W-1:0] res;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, lat, bc, res);
        checks++;
        if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", res); end
        checks++;
        if (lat !== FULL_LAT) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, FULL_LAT); end
        checks++;
        if (bc !== FULL_LAT - 1 || busy !== 1'b0) begin
            errors++; $display("FAIL mul_busy cycles %0d busy_at_done %b want %0d 0", bc, busy, FULL_LAT - 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse done=%b want 0", done); end
    endtask

    task automatic test_mulh;
        logic [2:0]   f[3]   = '{3'b001, 3'b011, 3'b010};
        logic [W-1:0] a[3]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] b[3]   = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002};
        logic [W-1:0] exp[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat, bc;
        logic [W-1:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(f[i], a[i], b[i], lat, bc, res);
            checks++;
            if (res !== exp[i] || lat !== FULL_LAT) begin
                errors++;
                $display("FAIL mulh_%0d got %h lat %0d want %h lat %0d", i, res, lat, exp[i], FULL_LAT);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]   f[4]   = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [W-1:0] a[4]   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [W-1:0] b[4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [W-1:0] exp[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int           el[4]  = '{FULL_LAT, HIT_LAT, FULL_LAT, HIT_LAT};
        int lat, bc;
        logic [W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], lat, bc, res);
            checks++;
            if (res !== exp[i] || lat !== el[i]) begin
                errors++;
                $display("FAIL div_%0d got %h lat %0d want %h lat %0d", i, res, lat, exp[i], el[i]);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]   f[4]   = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [W-1:0] a[4]   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [W-1:0] b[4]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [W-1:0] exp[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int lat, bc;
        logic [W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], b[i], lat, bc, res);
            checks++;
            if (res !== exp[i] || lat !== 1) begin
                errors++;
                $display("FAIL special_%0d got %h lat %0d want %h lat 1", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_flush;
        logic [W-1:0] prev;
        int seen;
        prev = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy busy=%b want 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle busy=%b done=%b want 0 0", busy, done);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || result !== prev) begin
            errors++; $display("FAIL flush_no_done dones %0d result %h want 0 %h", seen, result, prev);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (result !== 32'd14 || lat !== FULL_LAT) begin
            errors++; $display("FAIL b2b_first got %h lat %0d want 0000000e lat %0d", result, lat, FULL_LAT);
        end
        start = 1'b1; funct3 = 3'b111;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (result !== 32'd2 || lat !== HIT_LAT) begin
            errors++; $display("FAIL b2b_second got %h lat %0d want 00000002 lat %0d", result, lat, HIT_LAT);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, ndone;
        logic [W-1:0] res;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 0; ndone = 0; res = '0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 5) begin start = 1'b1; rs1_data = 32'd2; rs2_data = 32'd2; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin lat = c; res = result; end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || lat !== FULL_LAT || res !== 32'd15) begin
            errors++;
            $display("FAIL busy_ignore dones %0d lat %0d result %h want 1 %0d 0000000f", ndone, lat, res, FULL_LAT);
        end
    endtask

    task automatic test_async_reset;
        int lat, bc;
        logic [W-1:0] res;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result} !== {2'b00, {W{1'b0}}}) begin
            errors++; $display("FAIL async_reset busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 32'd3, 32'd4, lat, bc, res);
        checks++;
        if (res !== 32'd12 || lat !== FULL_LAT) begin
            errors++; $display("FAIL post_reset_mul got %h lat %0d want 0000000c lat %0d", res, lat, FULL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
